// File: rtl/g15_key_conditioner.sv
// Contact conditioner: synchronize, debounce and edge-detect N_CH keys, then pick one key at a time
// through a two-state interlock. "release" is a reserved word, so the release pulses are on port rel.
module g15_key_conditioner #(
    parameter int unsigned      N_CH        = 18,
    parameter int unsigned      DEBOUNCE_MS = 5,
    parameter logic [N_CH-1:0]  INVERT      = '0,
    parameter int unsigned      IW          = $clog2(N_CH)
) (
    input  logic            CLOCK,
    input  logic            rst,
    input  logic            tick_ms,
    input  logic [N_CH-1:0] raw_in,
    input  logic            ovr_clr,
    output logic [N_CH-1:0] stable,
    output logic [N_CH-1:0] press,
    output logic [N_CH-1:0] rel,
    output logic            any_key,
    output logic            key_valid,
    output logic [IW-1:0]   key_code,
    output logic            key_held,
    output logic            multi,
    output logic            overrun
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] HELD = 1'b1;

    logic [N_CH-1:0] sync_q1;
    logic [N_CH-1:0] sync_q2;
    logic [N_CH-1:0] stable_prev;

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= raw_in ^ INVERT;
            sync_q2 <= sync_q1;
        end
    end

    if (DEBOUNCE_MS == 0) begin : g_bypass
        always_ff @(posedge CLOCK) begin
            if (rst) begin
                stable <= '0;
            end else begin
                stable <= sync_q2;
            end
        end
    end else begin : g_debounce
        localparam int unsigned     CW       = $clog2(DEBOUNCE_MS + 1);
        localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_MS - 1);

        logic [CW-1:0] cnt_q [N_CH];

        // A channel's counter only advances on ticks while its synchronized level disagrees.
        always_ff @(posedge CLOCK) begin
            if (rst) begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    cnt_q[i] <= '0;
                end
                stable <= '0;
            end else begin
                for (int i = 0; i < int'(N_CH); i++) begin
                    if (sync_q2[i] == stable[i]) begin
                        cnt_q[i] <= '0;
                    end else if (tick_ms) begin
                        if (cnt_q[i] == CNT_LAST) begin
                            stable[i] <= sync_q2[i];
                            cnt_q[i]  <= '0;
                        end else begin
                            cnt_q[i] <= cnt_q[i] + CW'(1);
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            stable_prev <= '0;
            press       <= '0;
            rel         <= '0;
            any_key     <= 1'b0;
        end else begin
            stable_prev <= stable;
            press       <= stable & ~stable_prev;
            rel         <= ~stable & stable_prev;
            any_key     <= |stable;
        end
    end

    function automatic logic [IW-1:0] lowest_index(input logic [N_CH-1:0] v);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = int'(N_CH) - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = IW'(i);
            end
        end
        return idx;
    endfunction

    logic [0:0]      state_q;
    logic [IW-1:0]   held_q;
    logic [N_CH-1:0] held_mask;
    logic            held_rel;
    logic [N_CH-1:0] others;
    logic [N_CH-1:0] cand;
    logic            accept;
    logic            ovr_set;

    always_comb begin
        held_mask = '0;
        held_mask = N_CH'(1) << held_q;
        held_rel  = |(rel & held_mask);
        others    = press & ~held_mask;
        cand      = '0;
        ovr_set   = 1'b0;
        if (state_q == IDLE) begin
            cand = press;
        end else if (held_rel) begin
            // Release of the held key hands over to a simultaneous press without overrun.
            cand = others;
        end else begin
            ovr_set = |others;
        end
        accept = |cand;
    end

    always_ff @(posedge CLOCK) begin
        if (rst) begin
            state_q   <= IDLE;
            held_q    <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            multi     <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            key_valid <= accept;
            multi     <= accept && |(cand & (cand - N_CH'(1)));
            if (accept) begin
                state_q  <= HELD;
                held_q   <= lowest_index(cand);
                key_code <= lowest_index(cand);
            end else if (state_q == HELD && held_rel) begin
                state_q <= IDLE;
            end
            if (ovr_set) begin
                overrun <= 1'b1;
            end else if (ovr_clr) begin
                overrun <= 1'b0;
            end
        end
    end

    assign key_held = (state_q == HELD);

endmodule
